// File: rtl/if_stage.sv
// Instruction fetch: PC register, byte-serial word assembly over the shared memory bus, IF/ID register.
// Latency: uncached fetch takes 5 cycles in FETCH plus 1 in HAVE. With ICACHE_EN, a hit takes 1 cycle in FETCH plus 1 in HAVE.
// Backpressure: stall_if is raised while no word is ready. stall_pcreg and stall_if_id hold or bubble the registers.
//
// Optional feature macro: ICACHE_EN. It adds a direct-mapped, one-word-per-line instruction cache of ICACHE_LINES lines.

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef ICACHE_EN
    ,
    parameter int ICACHE_LINES = 128
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall_pcreg,
    input  logic [1:0]  stall_if_id,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [31:0] mem_a,
    output logic        stall_if,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HAVE  = 1'b1
    } state_t;

    localparam logic [1:0]  CMD_PASS = 2'b00;
    localparam logic [1:0]  CMD_BUBB = 2'b10;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] byte_buf_q, byte_buf_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    // The fourth byte has arrived and the assembled word is complete this cycle.
    logic        word_done;
    logic [31:0] word_asm;
    logic        cache_hit;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             cache_data [ICACHE_LINES];
    logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_vld_q, cache_vld_d;
    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic                    fill_en;

    assign pc_idx    = pc_q[IDX_W+1:2];
    assign pc_tag    = pc_q[31:IDX_W+2];
    // Lookups happen only at the start of a fetch. A hit skips the bus entirely.
    assign cache_hit = (state_q == FETCH) && (cnt_q == 3'd0) &&
                       cache_vld_q[pc_idx] && (cache_tag[pc_idx] == pc_tag);
    // A word discarded by a jump in the same cycle is not cached.
    assign fill_en   = word_done && !jump_en;

    // Line valid bits: set on fill.
    always_comb begin
        cache_vld_d = cache_vld_q;
        if (fill_en) begin
            cache_vld_d[pc_idx] = 1'b1;
        end
    end

    // Line valid bits: cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
        end
    end

    // Data and tag storage needs no reset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            cache_data[pc_idx] <= word_asm;
            cache_tag[pc_idx]  <= pc_tag;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign word_asm  = {mem_din, byte_buf_q};
    assign word_done = (state_q == FETCH) && !cache_hit && mem_gnt && (cnt_q == 3'd4);

    // The stall request decodes registered state only, so it has no path from the controller's commands.
    assign stall_if = (state_q == FETCH);
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;

    // Bus request: byte addresses pc+0..pc+3 are issued while cnt<4. There is no request during reset or on a cache hit.
    always_comb begin
        mem_rd = 1'b0;
        mem_a  = 32'h0000_0000;
        if (!rst && (state_q == FETCH) && (cnt_q < 3'd4) && !cache_hit) begin
            mem_rd = 1'b1;
            mem_a  = pc_q + {29'b0, cnt_q};
        end
    end

    // Next state for fetch sequencing, PC, IF/ID and jump redirect.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        byte_buf_d = byte_buf_q;
        inst_buf_d = inst_buf_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        case (state_q)
            FETCH: begin
`ifdef ICACHE_EN
                if (cache_hit) begin
                    inst_buf_d = cache_data[pc_idx];
                    state_d    = HAVE;
                end else
`endif
                if (!mem_gnt) begin
                    // Losing the bus drops the partial word. The fetch restarts at pc+0.
                    cnt_d = 3'd0;
                end else if (cnt_q == 3'd4) begin
                    inst_buf_d = word_asm;
                    state_d    = HAVE;
                    cnt_d      = 3'd0;
                end else begin
                    // mem_din carries the byte addressed in the previous cycle, which is byte cnt-1.
                    case (cnt_q)
                        3'd1:    byte_buf_d[7:0]   = mem_din;
                        3'd2:    byte_buf_d[15:8]  = mem_din;
                        3'd3:    byte_buf_d[23:16] = mem_din;
                        default: byte_buf_d        = byte_buf_q;
                    endcase
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HAVE: begin
                // The PC has no bubble form, so Hold and Bubb both keep it.
                if (stall_pcreg == CMD_PASS) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        case (stall_if_id)
            CMD_PASS: begin
                id_pc_d    = pc_q;
                id_inst_d  = inst_buf_q;
                id_valid_d = 1'b1;
            end
            CMD_BUBB: begin
                id_pc_d    = 32'h0000_0000;
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
            default: begin
                id_pc_d    = id_pc_q;
                id_inst_d  = id_inst_q;
                id_valid_d = id_valid_q;
            end
        endcase

        // A redirect wins over everything and discards any fetched or in-flight word.
        if (jump_en) begin
            pc_d       = jump_addr;
            state_d    = FETCH;
            cnt_d      = 3'd0;
            inst_buf_d = inst_buf_q;
            id_pc_d    = 32'h0000_0000;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end
    end

    // State registers. Reset overrides jump and all stall commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 3'd0;
            byte_buf_q <= 24'h0;
            inst_buf_q <= NOP_INST;
            id_pc_q    <= 32'h0000_0000;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            byte_buf_q <= byte_buf_d;
            inst_buf_q <= inst_buf_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage. It contains a byte memory model and a stall controller model.
// A scoreboard of expected IF/ID contents is filled when the controller issues Pass.
// Directed phases: reset, free run, grant loss, hold, jump collision, mid-fetch reset, and the cached loop when ICACHE_EN is defined.

module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  PASS = 2'b00;
    localparam logic [1:0]  HOLD = 2'b01;
    localparam logic [1:0]  BUBB = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall_pcreg;
    logic [1:0]  stall_if_id;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        mem_gnt;
    logic [7:0]  mem_din = 8'h00;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic        stall_if;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    logic        hold_req;
    logic        keep_id;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_pcreg(stall_pcreg),
        .stall_if_id(stall_if_id),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_gnt    (mem_gnt),
        .mem_din    (mem_din),
        .mem_rd     (mem_rd),
        .mem_a      (mem_a),
        .stall_if   (stall_if),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid)
    );

    // Stall controller model. It passes when IF has a word, bubbles IF/ID otherwise, and can hold on request.
    always_comb begin
        stall_pcreg = (hold_req || stall_if) ? HOLD : PASS;
        if (hold_req)      stall_if_id = HOLD;
        else if (stall_if) stall_if_id = keep_id ? HOLD : BUBB;
        else               stall_if_id = PASS;
    end

    // Byte memory: read data returns one cycle after the address.
    logic [7:0] mem [512];
    always @(posedge clk) mem_din <= mem[mem_a[8:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [8:0] b;
        b = a[8:0];
        return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         sb_ent;
    logic        mon_on = 1'b0;
    logic        pend   = 1'b0;
    logic        bub    = 1'b1;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] e_pc   = 32'h0;
    logic [31:0] e_inst = 32'h13;
    logic        e_vld  = 1'b0;

    // Scoreboard. It pops the entry pushed by last cycle's Pass, checks IF/ID every cycle,
    // then records this cycle's command and tracks the architectural PC.
    always @(negedge clk) begin
        if (mon_on) begin
            if (pend) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    sb_ent = sb_q.pop_front();
                    e_pc   = sb_ent.pc;
                    e_inst = sb_ent.inst;
                    e_vld  = 1'b1;
                end
            end else if (bub) begin
                e_pc   = 32'h0;
                e_inst = 32'h0000_0013;
                e_vld  = 1'b0;
            end
            chk("id_valid", {31'b0, id_valid}, {31'b0, e_vld});
            chk("id_pc", id_pc, e_pc);
            chk("id_inst", id_inst, e_inst);

            pend = 1'b0;
            bub  = 1'b0;
            if (rst) begin
                bub    = 1'b1;
                exp_pc = RESET_PC;
            end else if (jump_en) begin
                bub    = 1'b1;
                exp_pc = jump_addr;
            end else begin
                if (stall_if_id == PASS) begin
                    sb_q.push_back({exp_pc, word_at(exp_pc)});
                    pend = 1'b1;
                end else if (stall_if_id == BUBB) begin
                    bub = 1'b1;
                end
                if (stall_pcreg == PASS) exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic wait_have();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (stall_if === 1'b0) seen = 1'b1;
        end
        if (!seen) chk("wait_have_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pc(input logic [31:0] target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clk); #1;
            if (exp_pc == target) seen = 1'b1;
        end
        if (!seen) chk("wait_pc_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        mem_gnt   = 1'b1;
        hold_req  = 1'b0;
        keep_id   = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h10; mem[7] = 8'h00;

        // Reset state
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall_if", {31'b0, stall_if}, 32'd1);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);

        // Free run: four issue cycles at pc+0..3, then a capture cycle, then HAVE
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("issue_rd", {31'b0, mem_rd}, 32'd1);
            chk("issue_a", mem_a, RESET_PC + 32'(k));
            chk("issue_stall", {31'b0, stall_if}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("capture_stall", {31'b0, stall_if}, 32'd1);
        chk("capture_rd", {31'b0, mem_rd}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("have_stall", {31'b0, stall_if}, 32'd0);
        chk("have_rd", {31'b0, mem_rd}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("first_inst", id_inst, 32'h0000_0013);
        chk("first_pc", id_pc, 32'h0);
        chk("first_valid", {31'b0, id_valid}, 32'd1);

        // Grant loss: drop mem_gnt in the 3rd FETCH cycle for 2 cycles
        wait_have();
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("gntloss_rd", {31'b0, mem_rd}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("gntloss_rd2", {31'b0, mem_rd}, 32'd1);
        chk("gntloss_a", mem_a, exp_pc);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("restart_a0", mem_a, exp_pc);
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart_a1", mem_a, exp_pc + 32'd1);

        // Downstream hold: IF/ID keeps a real instruction while the next word waits in HAVE
        keep_id = 1'b1;
        wait_have();
        @(posedge clk); #1;
        wait_have();
        hold_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_stall", {31'b0, stall_if}, 32'd0);
            chk("hold_rd", {31'b0, mem_rd}, 32'd0);
            chk("hold_valid", {31'b0, id_valid}, 32'd1);
            chk("hold_pc", id_pc, exp_pc - 32'd4);
            chk("hold_inst", id_inst, word_at(exp_pc - 32'd4));
            @(posedge clk); #1;
        end
        hold_req = 1'b0;
        keep_id  = 1'b0;

        // Jump collision with HAVE+Pass
        jump_en   = 1'b1;
        jump_addr = 32'h0000_0100;
        @(posedge clk); #1;
        jump_en = 1'b0;
        @(negedge clk);
        chk("jump_valid", {31'b0, id_valid}, 32'd0);
        chk("jump_a", mem_a, 32'h0000_0100);
        chk("jump_rd", {31'b0, mem_rd}, 32'd1);
        chk("jump_stall", {31'b0, stall_if}, 32'd1);

        // Mid-fetch reset at cnt=2
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cyc_rd", {31'b0, mem_rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_a", mem_a, RESET_PC);
        chk("midrst_rd", {31'b0, mem_rd}, 32'd1);
        chk("midrst_valid", {31'b0, id_valid}, 32'd0);
        chk("midrst_inst", id_inst, 32'h0000_0013);
        chk("midrst_pc", id_pc, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_a1", mem_a, RESET_PC + 32'd1);

        // Run the first pass of the loop 0,4 (lines are filled when ICACHE_EN is defined)
        wait_pc(RESET_PC + 32'd8);

`ifdef ICACHE_EN
        // Cached loop: jump back to 0 and expect hits at 0 and 4, then a miss at 8
        jump_en   = 1'b1;
        jump_addr = RESET_PC;
        @(posedge clk); #1;
        jump_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cache_stall", {31'b0, stall_if}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cache_rd", {31'b0, mem_rd}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("cache_miss_rd", {31'b0, mem_rd}, 32'd1);
        chk("cache_miss_a", mem_a, RESET_PC + 32'd8);
`endif

        repeat (20) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
